rf_wb_queue: RTL and testbench

RF_WB_QUEUE -- requirements
Module: rf_wb_queue

---
 rtl/rf_wb_queue_if.sv | 41 ++++
 rtl/rf_wb_queue.sv | 106 ++++++++++
 tb/tb_rf_wb_queue.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/rf_wb_queue_if.sv
// Writeback queue bus: ALU/load requests, register-file write port, decode-stage hazard lookup.
// fwd_d1/fwd_d2 exist only when RF_WB_FWD_EN is defined.
interface rf_wb_queue_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        write_e;
  logic [4:0]  rd;
  logic [31:0] write_d;
  logic [4:0]  reg_s1;
  logic [4:0]  reg_s2;
  logic        pend_s1;
  logic        pend_s2;
`ifdef RF_WB_FWD_EN
  logic [31:0] fwd_d1;
  logic [31:0] fwd_d2;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, reg_s1, reg_s2,
    input  alu_ready, mem_ready, write_e, rd, write_d, pend_s1, pend_s2, fwd_d1, fwd_d2
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, reg_s1, reg_s2,
    output alu_ready, mem_ready, write_e, rd, write_d, pend_s1, pend_s2, fwd_d1, fwd_d2
  );
`else
  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, reg_s1, reg_s2,
    input  alu_ready, mem_ready, write_e, rd, write_d, pend_s1, pend_s2
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, reg_s1, reg_s2,
    output alu_ready, mem_ready, write_e, rd, write_d, pend_s1, pend_s2
  );
`endif
endinterface

// File: rtl/rf_wb_queue.sv
// Register-file writeback queue: mem-over-alu arbitration into a circular FIFO, one RF write per cycle.
// Optional forwarding of youngest pending data to decode under macro RF_WB_FWD_EN.
module rf_wb_queue #(
  parameter int DEPTH = 4
) (
  input logic         clk,
  input logic         rst,
  rf_wb_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [4:0]    q_rd   [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic        full;
  logic        empty;
  logic        mem_acc;
  logic        alu_acc;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic        enq;
  logic        pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign mem_acc = bus.mem_valid && !full;
  assign alu_acc = bus.alu_valid && !full && !bus.mem_valid;
  assign in_rd   = mem_acc ? bus.mem_rd : bus.alu_rd;
  assign in_data = mem_acc ? bus.mem_data : bus.alu_data;
  // x0 writes complete their handshake but never occupy an entry
  assign enq     = (mem_acc || alu_acc) && (in_rd != 5'd0);
  assign pop     = !empty;

  assign bus.mem_ready = !full;
  assign bus.alu_ready = !full && !bus.mem_valid;
  assign bus.write_e   = !empty;
  assign bus.rd        = empty ? 5'd0 : q_rd[rd_ptr];
  assign bus.write_d   = empty ? 32'd0 : q_data[rd_ptr];

  always_ff @(posedge clk) begin
    if (enq) begin
      q_rd[wr_ptr]   <= in_rd;
      q_data[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(enq) - CW'(pop);
    end
  end

  logic          hit1;
  logic          hit2;
  logic [PW-1:0] idx;
`ifdef RF_WB_FWD_EN
  logic [31:0]   fwd1;
  logic [31:0]   fwd2;
`endif

  // Scan oldest to youngest so the last match is the youngest entry
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    idx  = '0;
`ifdef RF_WB_FWD_EN
    fwd1 = 32'd0;
    fwd2 = 32'd0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if (CW'(k) < count) begin
        if ((bus.reg_s1 != 5'd0) && (q_rd[idx] == bus.reg_s1)) begin
          hit1 = 1'b1;
`ifdef RF_WB_FWD_EN
          fwd1 = q_data[idx];
`endif
        end
        if ((bus.reg_s2 != 5'd0) && (q_rd[idx] == bus.reg_s2)) begin
          hit2 = 1'b1;
`ifdef RF_WB_FWD_EN
          fwd2 = q_data[idx];
`endif
        end
      end
    end
  end

  assign bus.pend_s1 = hit1;
  assign bus.pend_s2 = hit2;
`ifdef RF_WB_FWD_EN
  assign bus.fwd_d1  = fwd1;
  assign bus.fwd_d2  = fwd2;
`endif

endmodule

// File: tb/tb_rf_wb_queue.sv
// Bench for rf_wb_queue: directed scenarios plus random traffic against a queue-based reference model.
module tb_rf_wb_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rf_wb_queue_if bus ();
  rf_wb_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;
  wb_t mq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic pend_of(input logic [4:0] s);
    if (s == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i].rd == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] fwd_of(input logic [4:0] s);
    logic [31:0] v = 32'd0;
    if (s == 5'd0) return 32'd0;
    foreach (mq[i]) if (mq[i].rd == s) v = mq[i].data;
    return v;
  endfunction

  task automatic check_outputs();
    logic full;
    full = (mq.size() == DEPTH);
    check("mem_ready", 32'(bus.mem_ready), 32'(!full));
    check("alu_ready", 32'(bus.alu_ready), 32'(!full && !bus.mem_valid));
    check("write_e", 32'(bus.write_e), 32'(mq.size() != 0));
    check("rd", 32'(bus.rd), (mq.size() != 0) ? 32'(mq[0].rd) : 32'd0);
    check("write_d", bus.write_d, (mq.size() != 0) ? mq[0].data : 32'd0);
    check("pend_s1", 32'(bus.pend_s1), 32'(pend_of(bus.reg_s1)));
    check("pend_s2", 32'(bus.pend_s2), 32'(pend_of(bus.reg_s2)));
`ifdef RF_WB_FWD_EN
    check("fwd_d1", bus.fwd_d1, fwd_of(bus.reg_s1));
    check("fwd_d2", bus.fwd_d2, fwd_of(bus.reg_s2));
`endif
  endtask

  // Effect of the coming clock edge on the model
  task automatic model_edge();
    logic full, mem_acc, alu_acc;
    wb_t e;
    full    = (mq.size() == DEPTH);
    mem_acc = bus.mem_valid && !full;
    alu_acc = bus.alu_valid && !full && !bus.mem_valid;
    if (mq.size() != 0) void'(mq.pop_front());
    if (mem_acc && bus.mem_rd != 5'd0) begin
      e.rd = bus.mem_rd; e.data = bus.mem_data; mq.push_back(e);
    end else if (alu_acc && bus.alu_rd != 5'd0) begin
      e.rd = bus.alu_rd; e.data = bus.alu_data; mq.push_back(e);
    end
  endtask

  task automatic cycle(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md,
                       input logic [4:0] s1, input logic [4:0] s2);
    @(posedge clk);
    #1;
    bus.alu_valid = av; bus.alu_rd = ar; bus.alu_data = ad;
    bus.mem_valid = mv; bus.mem_rd = mr; bus.mem_data = md;
    bus.reg_s1 = s1; bus.reg_s2 = s2;
    #3;
    check_outputs();
    model_edge();
  endtask

  task automatic idle(input logic [4:0] s1, input logic [4:0] s2);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, s1, s2);
  endtask

  initial begin
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
    bus.reg_s1 = '0; bus.reg_s2 = '0;
    #2;
    check("rst write_e", 32'(bus.write_e), 32'd0);
    check("rst alu_ready", 32'(bus.alu_ready), 32'd1);
    check("rst mem_ready", 32'(bus.mem_ready), 32'd1);
    #20 rst = 1'b0;

    // Single ALU write, one-cycle latency
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    idle(5'd5, 5'd0);
    check("lat write_e", 32'(bus.write_e), 32'd1);
    check("lat rd", 32'(bus.rd), 32'd5);
    check("lat write_d", bus.write_d, 32'hDEADBEEF);
    idle(5'd5, 5'd0);
    check("lat done", 32'(bus.write_e), 32'd0);

    // Mem wins; ALU holds its request one more cycle
    cycle(1'b1, 5'd4, 32'h44, 1'b1, 5'd3, 32'h33, 5'd3, 5'd4);
    check("arb alu_ready", 32'(bus.alu_ready), 32'd0);
    cycle(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'd0, 5'd3, 5'd4);
    check("arb first rd", 32'(bus.rd), 32'd3);
    idle(5'd3, 5'd4);
    check("arb second rd", 32'(bus.rd), 32'd4);
    idle(5'd0, 5'd0);

    // x0 write is accepted and dropped
    cycle(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    check("x0 alu_ready", 32'(bus.alu_ready), 32'd1);
    idle(5'd0, 5'd0);
    check("x0 write_e", 32'(bus.write_e), 32'd0);

    // Both requesters held for six cycles, exercising pointer wrap
    for (int i = 0; i < 6; i++)
      cycle(1'b1, 5'(10 + i), 32'(i), 1'b1, 5'(20 + i), 32'(100 + i), 5'(20 + i), 5'(19 + i));
    idle(5'd0, 5'd0);

    // Back-to-back rd=7 entries, lookup of reg 7
    cycle(1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
    cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h22, 5'd7, 5'd0);
    check("dup pend_s1", 32'(bus.pend_s1), 32'd1);
    idle(5'd7, 5'd0);
    idle(5'd7, 5'd0);
    check("dup retired", 32'(bus.pend_s1), 32'd0);

    // Asynchronous reset with an entry queued
    cycle(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 5'd9, 5'd9);
    @(posedge clk);
    #2;
    bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("arst write_e", 32'(bus.write_e), 32'd0);
    check("arst rd", 32'(bus.rd), 32'd0);
    check("arst pend_s1", 32'(bus.pend_s1), 32'd0);
    check("arst pend_s2", 32'(bus.pend_s2), 32'd0);
    mq.delete();
    @(negedge clk);
    rst = 1'b0;
    idle(5'd9, 5'd9);
    idle(5'd9, 5'd9);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
